// File: rtl/ws2812_driver.sv
// WS2812 serial frame driver: GRB, MSB first, NUM_LEDS pixels, then a low latch gap.
// Output follows start by one cycle; start is ignored while busy (no backpressure, no queueing).
module ws2812_driver #(
  parameter int T0H      = 8,
  parameter int T1H      = 16,
  parameter int TBIT     = 25,
  parameter int TRESET   = 1000,
  parameter int NUM_LEDS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       led_out
);

  localparam int CMAX = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [CW-1:0] TBIT_END = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRST_END = CW'(TRESET - 1);
  localparam logic [PW-1:0] PIX_END  = PW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t        state;
  logic [23:0]   shreg;
  logic [23:0]   cap;
  logic [CW-1:0] cnt;
  logic [4:0]    bitc;
  logic [PW-1:0] pix;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cap     <= '0;
      cnt     <= '0;
      bitc    <= '0;
      pix     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      led_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          led_out <= 1'b0;
          if (start) begin
            shreg   <= {green, red, blue};
            cap     <= {green, red, blue};
            cnt     <= '0;
            bitc    <= '0;
            pix     <= '0;
            busy    <= 1'b1;
            led_out <= 1'b1;  // every bit period opens with a high phase
            state   <= SEND;
          end
        end
        SEND: begin
          if (cnt == TBIT_END) begin
            cnt <= '0;
            if (bitc == 5'd23) begin
              bitc  <= '0;
              shreg <= cap;
              if (pix == PIX_END) begin
                led_out <= 1'b0;
                state   <= LATCH;
              end else begin
                pix     <= pix + PW'(1);
                led_out <= 1'b1;
              end
            end else begin
              bitc    <= bitc + 5'd1;
              shreg   <= {shreg[22:0], 1'b0};
              led_out <= 1'b1;
            end
          end else begin
            cnt     <= cnt_nxt;
            led_out <= (cnt_nxt < (shreg[23] ? T1H_C : T0H_C));
          end
        end
        LATCH: begin
          led_out <= 1'b0;
          if (cnt == TRST_END) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          led_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
